// File: rtl/thermostat_ctrl.sv
// Thermostat controller: heat/cool hysteresis FSM with
// minimum dwell in each active mode and a sensor-timeout fault.
module thermostat_ctrl #(
  parameter int WIDTH     = 5,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int MIN_DWELL = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] temperature,
  input  logic             temp_valid,
  input  logic             heat_en,
  input  logic             cool_en,
  output logic             heating,
  output logic             cooling,
  output logic [1:0]       state,
  output logic             fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_HEAT  = 2'b01,
    S_COOL  = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH-1:0] T_HON  = WIDTH'(HEAT_ON);
  localparam logic [WIDTH-1:0] T_HOFF = WIDTH'(HEAT_OFF);
  localparam logic [WIDTH-1:0] T_CON  = WIDTH'(COOL_ON);
  localparam logic [WIDTH-1:0] T_COFF = WIDTH'(COOL_OFF);

  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(TIMEOUT);
  localparam logic [WW-1:0] WDOG_TRIP = WW'(TIMEOUT - 1);

  // Reject illegal threshold ordering or counter limits at elaboration
  if (!(HEAT_ON < HEAT_OFF && HEAT_OFF <= COOL_OFF &&
        COOL_OFF < COOL_ON && MIN_DWELL >= 1 &&
        TIMEOUT >= 2)) begin : g_bad_params
    $error("thermostat_ctrl: illegal parameter set");
  end

  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic dwell_done;
  logic timeout;

  assign dwell_done = (dwell_q == DWELL_MAX);
  // Fault fires on the edge that would take the watchdog to TIMEOUT
  assign timeout = !temp_valid && (wdog_q >= WDOG_TRIP);

  // Next-state, dwell and watchdog computation
  always_comb begin
    state_d = state_q;
    dwell_d = '0;
    wdog_d  = wdog_q;

    if (temp_valid)
      wdog_d = '0;
    else if (wdog_q != WDOG_MAX)
      wdog_d = wdog_q + 1'b1;

    if (timeout) begin
      state_d = S_FAULT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (temp_valid) begin
            if (heat_en && temperature <= T_HON)
              state_d = S_HEAT;
            else if (cool_en && temperature >= T_CON)
              state_d = S_COOL;
          end
        end
        S_HEAT: begin
          if (!heat_en)
            state_d = S_IDLE;
          else if (temp_valid && dwell_done &&
                   temperature >= T_HOFF)
            state_d = S_IDLE;
        end
        S_COOL: begin
          if (!cool_en)
            state_d = S_IDLE;
          else if (temp_valid && dwell_done &&
                   temperature <= T_COFF)
            state_d = S_IDLE;
        end
        S_FAULT: begin
          if (temp_valid)
            state_d = S_IDLE;
        end
      endcase
    end

    // Dwell runs only while remaining in an active mode
    if ((state_q == S_HEAT || state_q == S_COOL) &&
        state_d == state_q) begin
      if (dwell_q != DWELL_MAX)
        dwell_d = dwell_q + 1'b1;
      else
        dwell_d = dwell_q;
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dwell_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      wdog_q  <= wdog_d;
    end
  end

  assign state   = state_q;
  assign heating = (state_q == S_HEAT);
  assign cooling = (state_q == S_COOL);
  assign fault   = (state_q == S_FAULT);

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Directed bench for thermostat_ctrl at default parameters.
// Expected values are hand-derived per scenario.
module tb_thermostat_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] temperature;
  logic       temp_valid;
  logic       heat_en;
  logic       cool_en;
  logic       heating;
  logic       cooling;
  logic [1:0] state;
  logic       fault;

  int n_run;
  int n_fail;

  thermostat_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .temperature (temperature),
    .temp_valid  (temp_valid),
    .heat_en     (heat_en),
    .cool_en     (cool_en),
    .heating     (heating),
    .cooling     (cooling),
    .state       (state),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_outs(input string tag,
                          input logic [1:0] st);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".heat"}, 32'(heating), 32'(st == 2'b01));
    chk({tag, ".cool"}, 32'(cooling), 32'(st == 2'b10));
    chk({tag, ".fault"}, 32'(fault), 32'(st == 2'b11));
  endtask

  initial begin
    n_run       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    temperature = 5'd0;
    temp_valid  = 1'b0;
    heat_en     = 1'b0;
    cool_en     = 1'b0;

    // reset, then watchdog runs out 16 clocks later
    tick(2);
    chk_outs("rst", 2'b00);
    rst = 1'b0;
    tick(15);
    chk_outs("wd15", 2'b00);
    tick();
    chk_outs("wd16", 2'b11);
    tick(3);
    chk_outs("wd_hold", 2'b11);

    // fault recovery does not evaluate the sample
    heat_en     = 1'b1;
    temperature = 5'd15;
    temp_valid  = 1'b1;
    tick();
    chk_outs("flt_rec", 2'b00);

    // heat entry and dwell-gated exit
    tick();
    chk_outs("heat_in", 2'b01);
    temperature = 5'd20;
    tick(4);
    chk_outs("dwell4", 2'b01);
    tick();
    chk_outs("heat_out", 2'b00);

    // enable drop overrides dwell
    temperature = 5'd15;
    tick();
    chk_outs("h2_in", 2'b01);
    tick();
    heat_en = 1'b0;
    tick();
    chk_outs("en_drop", 2'b00);

    // timeout while heating
    heat_en = 1'b1;
    tick();
    chk_outs("h3_in", 2'b01);
    temp_valid = 1'b0;
    tick(15);
    chk_outs("h_wd15", 2'b01);
    tick();
    chk_outs("h_wd16", 2'b11);
    temperature = 5'd21;
    temp_valid  = 1'b1;
    tick();
    chk_outs("h_rec", 2'b00);

    // valid on the would-be timeout edge clears watchdog
    temperature = 5'd19;
    temp_valid  = 1'b0;
    tick(15);
    temp_valid = 1'b1;
    tick();
    chk_outs("wd_save", 2'b00);
    temp_valid = 1'b0;
    tick(15);
    chk_outs("wd_fresh", 2'b00);
    tick();
    chk_outs("wd_trip", 2'b11);
    temp_valid = 1'b1;
    tick();
    chk_outs("wd_rec", 2'b00);

    // reset mid-cool, fresh dwell afterwards
    heat_en     = 1'b0;
    cool_en     = 1'b1;
    temperature = 5'd25;
    tick();
    chk_outs("cool_in", 2'b10);
    tick(2);
    rst = 1'b1;
    tick();
    chk_outs("cool_rst", 2'b00);
    rst = 1'b0;
    tick();
    chk_outs("cool_re", 2'b10);
    temperature = 5'd20;
    tick(4);
    chk_outs("cdwell4", 2'b10);
    tick();
    chk_outs("cool_out", 2'b00);

    // ramp 15..25, 3 clocks per step, both enables on
    heat_en = 1'b1;
    cool_en = 1'b1;
    for (int t = 15; t <= 25; t++) begin
      for (int k = 0; k < 3; k++) begin
        int e;
        logic [1:0] ex;
        e = (t - 15) * 3 + k + 1;
        ex = (e <= 15) ? 2'b01 :
             (e <= 21) ? 2'b00 : 2'b10;
        temperature = 5'(t);
        tick();
        chk($sformatf("ramp%0d", e), 32'(state), 32'(ex));
        chk("ramp_excl", 32'(heating & cooling), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
